// File: rtl/fb_cell_fetch.sv
// Cell-fetch and scan sequencer: prefetches framebuffer cell words one cell ahead of the beam.
// Optional double-buffered page flip at frame start when FB_CELL_FETCH_FLIP_EN is defined.
//
// state  | meaning
// IDLE   | between lines, waiting for lineStart
// PRIME0 | read of the row's first cell in flight
// PRIME1 | read of the second cell; first word lands in cur
// WAIT   | second word lands in next
// RUN    | pixels stepping, one-ahead prefetch per cell boundary
module fb_cell_fetch #(
    parameter int COLS    = 40,
    parameter int ROWS    = 25,
    parameter int CELL_PX = 8,
    parameter int IX_W    = 14,
    parameter int DATA_W  = 64,
    localparam int PX_W   = $clog2(CELL_PX),
    localparam int CW     = $clog2(COLS)
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              frameStart_i,
    input  logic              lineStart_i,
    input  logic              pixStep_i,
    output logic [IX_W:0]     memAddr_o,
    output logic              memRd_o,
    input  logic [DATA_W-1:0] memData_i,
    output logic [IX_W-1:0]   cellIx_o,
    output logic [DATA_W-1:0] cellData_o,
    output logic [PX_W-1:0]   cellPx_o,
    output logic [PX_W-1:0]   cellLn_o,
    output logic              cellValid_o,
    input  logic              flipReq_i,
    input  logic              flipPage_i,
    output logic              flipAck_o,
    output logic              underrun_o
);

    typedef enum logic [2:0] {IDLE, PRIME0, PRIME1, WAIT, RUN} state_t;

    state_t            state_q;
    logic [IX_W-1:0]   rowBase_q;
    logic [CW-1:0]     colCnt_q;
    logic [PX_W-1:0]   cellPx_q;
    logic [PX_W-1:0]   cellLn_q;
    logic              frameDone_q;
    logic [DATA_W-1:0] cur_q;
    logic [DATA_W-1:0] next_q;
    logic [IX_W:0]     memAddr_q;
    logic              memRd_q;
    logic              runRd_q;
    logic              underrun_q;
    logic              page_d;
    logic [IX_W-1:0]   prefetchIx_d;

`ifdef FB_CELL_FETCH_FLIP_EN
    logic page_q;
    logic pendValid_q;
    logic pendPage_q;
    logic flipAck_q;

    // A request arriving with frameStart stays pending for the following frame.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            page_q      <= 1'b0;
            pendValid_q <= 1'b0;
            pendPage_q  <= 1'b0;
            flipAck_q   <= 1'b0;
        end else begin
            flipAck_q <= frameStart_i && pendValid_q;
            if (frameStart_i && pendValid_q) begin
                page_q      <= pendPage_q;
                pendValid_q <= 1'b0;
            end
            if (flipReq_i) begin
                pendValid_q <= 1'b1;
                pendPage_q  <= flipPage_i;
            end
        end
    end

    assign page_d    = (frameStart_i && pendValid_q) ? pendPage_q : page_q;
    assign flipAck_o = flipAck_q;
`else
    logic unused_flip;
    assign unused_flip = flipReq_i ^ flipPage_i;
    assign page_d      = 1'b0;
    assign flipAck_o   = 1'b0;
`endif

    assign prefetchIx_d = rowBase_q + IX_W'(colCnt_q) + IX_W'(2);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            rowBase_q   <= '0;
            colCnt_q    <= '0;
            cellPx_q    <= '0;
            cellLn_q    <= '0;
            frameDone_q <= 1'b0;
            cur_q       <= '0;
            next_q      <= '0;
            memAddr_q   <= '0;
            memRd_q     <= 1'b0;
            runRd_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            memRd_q <= 1'b0;
            runRd_q <= memRd_q && (state_q == RUN);
            if (runRd_q) next_q <= memData_i;
            if (pixStep_i && (state_q != RUN) && !frameDone_q) underrun_q <= 1'b1;
            if (lineStart_i && (state_q != IDLE) && !frameStart_i) underrun_q <= 1'b1;

            if (frameStart_i) begin
                rowBase_q   <= '0;
                cellLn_q    <= '0;
                colCnt_q    <= '0;
                cellPx_q    <= '0;
                frameDone_q <= 1'b0;
                if (lineStart_i) begin
                    state_q   <= PRIME0;
                    memRd_q   <= 1'b1;
                    memAddr_q <= {page_d, {IX_W{1'b0}}};
                end else begin
                    state_q <= IDLE;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (lineStart_i && !frameDone_q) begin
                            state_q   <= PRIME0;
                            memRd_q   <= 1'b1;
                            memAddr_q <= {page_d, rowBase_q};
                            colCnt_q  <= '0;
                            cellPx_q  <= '0;
                        end
                    end
                    PRIME0: begin
                        state_q   <= PRIME1;
                        memRd_q   <= 1'b1;
                        memAddr_q <= {page_d, rowBase_q + IX_W'(1)};
                    end
                    PRIME1: begin
                        cur_q   <= memData_i;
                        state_q <= WAIT;
                    end
                    WAIT: begin
                        next_q  <= memData_i;
                        state_q <= RUN;
                    end
                    RUN: begin
                        if (pixStep_i) begin
                            if (cellPx_q == PX_W'(CELL_PX - 1)) begin
                                cellPx_q <= '0;
                                cur_q    <= next_q;
                                if (colCnt_q == CW'(COLS - 1)) begin
                                    state_q  <= IDLE;
                                    colCnt_q <= '0;
                                    if (cellLn_q == PX_W'(CELL_PX - 1)) begin
                                        cellLn_q  <= '0;
                                        rowBase_q <= rowBase_q + IX_W'(COLS);
                                        if (rowBase_q == IX_W'((ROWS - 1) * COLS))
                                            frameDone_q <= 1'b1;
                                    end else begin
                                        cellLn_q <= cellLn_q + PX_W'(1);
                                    end
                                end else begin
                                    colCnt_q <= colCnt_q + CW'(1);
                                    if (int'(colCnt_q) + 2 < COLS) begin
                                        memRd_q   <= 1'b1;
                                        memAddr_q <= {page_d, prefetchIx_d};
                                    end
                                end
                            end else begin
                                cellPx_q <= cellPx_q + PX_W'(1);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign memAddr_o   = memAddr_q;
    assign memRd_o     = memRd_q;
    assign cellIx_o    = rowBase_q + IX_W'(colCnt_q);
    assign cellData_o  = cur_q;
    assign cellPx_o    = cellPx_q;
    assign cellLn_o    = cellLn_q;
    assign cellValid_o = (state_q == RUN);
    assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_fb_cell_fetch.sv
// Self-checking bench for fb_cell_fetch: read addresses go through a scoreboard queue,
// displayed cells are checked per pixel step against a bench memory model.
module tb_fb_cell_fetch;

    localparam int COLS    = 40;
    localparam int ROWS    = 5;
    localparam int CELL_PX = 8;
    localparam int IX_W    = 14;
    localparam int DATA_W  = 64;
`ifdef FB_CELL_FETCH_FLIP_EN
    localparam logic EXP_FLIP = 1'b1;
`else
    localparam logic EXP_FLIP = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              frameStart = 1'b0;
    logic              lineStart = 1'b0;
    logic              pixStep = 1'b0;
    logic [IX_W:0]     memAddr;
    logic              memRd;
    logic [DATA_W-1:0] memData = '0;
    logic [IX_W-1:0]   cellIx;
    logic [DATA_W-1:0] cellData;
    logic [2:0]        cellPx;
    logic [2:0]        cellLn;
    logic              cellValid;
    logic              flipReq = 1'b0;
    logic              flipPage = 1'b0;
    logic              flipAck;
    logic              underrun;

    int n_checks = 0;
    int n_fail   = 0;
    logic [IX_W:0] rd_q[$];

    fb_cell_fetch #(
        .COLS(COLS), .ROWS(ROWS), .CELL_PX(CELL_PX), .IX_W(IX_W), .DATA_W(DATA_W)
    ) dut (
        .clock_i(clock), .reset_ni(reset_n), .frameStart_i(frameStart),
        .lineStart_i(lineStart), .pixStep_i(pixStep), .memAddr_o(memAddr),
        .memRd_o(memRd), .memData_i(memData), .cellIx_o(cellIx),
        .cellData_o(cellData), .cellPx_o(cellPx), .cellLn_o(cellLn),
        .cellValid_o(cellValid), .flipReq_i(flipReq), .flipPage_i(flipPage),
        .flipAck_o(flipAck), .underrun_o(underrun)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] mem_word(input logic [14:0] a);
        return {a, ~a, a, ~a, 4'h5};
    endfunction

    // Read data appears the cycle after the strobe; 'bad' pattern otherwise.
    always @(posedge clock)
        memData <= memRd ? mem_word(memAddr) : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && memRd) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 64'(memRd), 64'd0);
            else chk("rd_addr", 64'(memAddr), 64'(rd_q.pop_front()));
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic run_line(input int row, input int ln, input logic pg, input int nsteps);
        int last_rd;
        last_rd = nsteps / CELL_PX + 1;
        if (last_rd > COLS - 1) last_rd = COLS - 1;
        for (int c = 0; c <= last_rd; c++) rd_q.push_back({pg, 14'(row * COLS + c)});
        lineStart = 1'b1;
        tick();
        lineStart = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < nsteps; i++) begin
            logic [14:0] ix;
            ix = 15'(row * COLS + i / CELL_PX);
            chk("cell_ix", 64'(cellIx), 64'(ix[13:0]));
            chk("cell_data", cellData, mem_word({pg, ix[13:0]}));
            if (i % CELL_PX == 0) begin
                chk("cell_valid", 64'(cellValid), 64'd1);
                chk("cell_px", 64'(cellPx), 64'd0);
                chk("cell_ln", 64'(cellLn), 64'(ln));
            end
            pixStep = 1'b1;
            tick();
        end
        pixStep = 1'b0;
        if (nsteps == COLS * CELL_PX) begin
            tick();
            chk("line_end_valid", 64'(cellValid), 64'd0);
            chk("line_end_underrun", 64'(underrun), 64'd0);
            chk("line_reads_done", 64'(rd_q.size()), 64'd0);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_addr"}, 64'(memAddr), 64'd0);
        chk({pfx, "_rd"}, 64'(memRd), 64'd0);
        chk({pfx, "_ix"}, 64'(cellIx), 64'd0);
        chk({pfx, "_data"}, cellData, 64'd0);
        chk({pfx, "_px"}, 64'(cellPx), 64'd0);
        chk({pfx, "_ln"}, 64'(cellLn), 64'd0);
        chk({pfx, "_valid"}, 64'(cellValid), 64'd0);
        chk({pfx, "_ack"}, 64'(flipAck), 64'd0);
        chk({pfx, "_underrun"}, 64'(underrun), 64'd0);
    endtask

    initial begin
        #3;
        check_all_zero("reset");
        tick();
        reset_n = 1'b1;
        tick();

        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        chk("ack_no_pending", 64'(flipAck), 64'd0);

        // Full frame on page 0; flip requested mid-frame, latest request wins.
        for (int l = 0; l < ROWS * CELL_PX; l++) begin
            run_line(l / CELL_PX, l % CELL_PX, 1'b0, COLS * CELL_PX);
            if (l == 2 || l == 3) begin
                flipReq = 1'b1;
                flipPage = (l == 3);
                tick();
                flipReq = 1'b0;
                flipPage = 1'b0;
                chk("ack_midframe", 64'(flipAck), 64'd0);
            end
            tick();
        end

        // Line after the last row: ignored, no read, no error, even with a stray pixStep.
        lineStart = 1'b1;
        tick();
        lineStart = 1'b0;
        repeat (4) tick();
        pixStep = 1'b1;
        tick();
        pixStep = 1'b0;
        repeat (4) tick();
        chk("frame_end_valid", 64'(cellValid), 64'd0);
        chk("frame_end_underrun", 64'(underrun), 64'd0);

        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        chk("flip_ack_pulse", 64'(flipAck), 64'(EXP_FLIP));
        tick();
        chk("flip_ack_single", 64'(flipAck), 64'd0);

        run_line(0, 0, EXP_FLIP, COLS * CELL_PX);
        tick();

        // Early pixStep during priming must raise the sticky error.
        rd_q.push_back({EXP_FLIP, 14'd0});
        rd_q.push_back({EXP_FLIP, 14'd1});
        lineStart = 1'b1;
        tick();
        lineStart = 1'b0;
        tick();
        pixStep = 1'b1;
        tick();
        pixStep = 1'b0;
        repeat (3) tick();
        chk("underrun_set", 64'(underrun), 64'd1);
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        tick();
        chk("underrun_sticky", 64'(underrun), 64'd1);
        chk("abort_valid", 64'(cellValid), 64'd0);

        // Reset between clock edges while running.
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        run_line(0, 0, EXP_FLIP, 20);
        chk("prereset_valid", 64'(cellValid), 64'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        chk("reads_before_reset", 64'(rd_q.size()), 64'd0);
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("idle_after_reset", 64'(memRd), 64'd0);
        run_line(0, 0, 1'b0, COLS * CELL_PX);
        repeat (3) tick();
        chk("final_queue_empty", 64'(rd_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
